// File: rtl/mem_access.sv
// RV32I memory stage: loads/stores over a request/ready/rvalid bus, forwards ALU results to writeback.
// Optional MEM_ALIGN_CHECK_EN faults misaligned halfword/word accesses instead of issuing them.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_i,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] s;
        case (f3[1:0])
            2'b00: begin
                case (lane)
                    2'b00:   s = 4'b0001;
                    2'b01:   s = 4'b0010;
                    2'b10:   s = 4'b0100;
                    default: s = 4'b1000;
                endcase
            end
            2'b01:   s = lane[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{sd[7:0]}};
            2'b01:   w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  dest_q, dest_d;

    logic bad_f3_s;
    logic misal_s;
    logic done_s;
    logic tmo_s;

    assign bad_f3_s = is_load ? ((func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111))
                              : (func3[2] || (func3 == 3'b011));

`ifdef MEM_ALIGN_CHECK_EN
    assign misal_s = ((func3[1:0] == 2'b01) && addr[0]) ||
                     ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misal_s = 1'b0;
`endif

    // A store completes on ready; a load needs its data, either with ready or later in WAIT_R.
    assign done_s = ((state_q == REQ) && mem_ready && (mem_we_q || mem_rvalid)) ||
                    ((state_q == WAIT_R) && mem_rvalid);
    assign tmo_s  = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        wb_valid_d    = 1'b0;
        wb_dest_d     = wb_dest_q;
        wb_data_d     = wb_data_q;
        fault_d       = 1'b0;
        fault_cause_d = 2'b00;
        cnt_d         = cnt_q;
        func3_d       = func3_q;
        lane_d        = lane_q;
        dest_d        = dest_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                if (valid_i && !is_load && !is_store) begin
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_i;
                    wb_data_d  = alu_result;
                end else if (valid_i && bad_f3_s) begin
                    wb_valid_d    = 1'b1;
                    wb_dest_d     = 5'd0;
                    wb_data_d     = 32'd0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'b10;
                end else if (valid_i && misal_s) begin
                    wb_valid_d    = 1'b1;
                    wb_dest_d     = 5'd0;
                    wb_data_d     = 32'd0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'b01;
                end else if (valid_i) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wstrb_d = is_store ? store_strb(func3, addr[1:0]) : 4'b0000;
                    mem_wdata_d = is_store ? store_lanes(func3, store_data) : 32'd0;
                    func3_d     = func3;
                    lane_d      = addr[1:0];
                    dest_d      = is_store ? 5'd0 : dest_i;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ, WAIT_R: begin
                cnt_d = cnt_q + CW'(1);
                if (done_s) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    cnt_d      = {CW{1'b0}};
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    wb_data_d  = mem_we_q ? 32'd0 : load_extract(func3_q, lane_q, mem_rdata);
                end else if (tmo_s) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    cnt_d         = {CW{1'b0}};
                    wb_valid_d    = 1'b1;
                    wb_dest_d     = 5'd0;
                    wb_data_d     = 32'd0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'b11;
                end else if ((state_q == REQ) && mem_ready) begin
                    state_d   = WAIT_R;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                cnt_d     = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers; synchronous reset discards any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_wstrb_q   <= 4'b0000;
            wb_valid_q    <= 1'b0;
            wb_dest_q     <= 5'd0;
            wb_data_q     <= 32'd0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            cnt_q         <= {CW{1'b0}};
            func3_q       <= 3'b000;
            lane_q        <= 2'b00;
            dest_q        <= 5'd0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            wb_valid_q    <= wb_valid_d;
            wb_dest_q     <= wb_dest_d;
            wb_data_q     <= wb_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            cnt_q         <= cnt_d;
            func3_q       <= func3_d;
            lane_q        <= lane_d;
            dest_q        <= dest_d;
        end
    end

    assign stall       = (state_q != IDLE);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign wb_valid    = wb_valid_q;
    assign wb_dest     = wb_dest_q;
    assign wb_data     = wb_data_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the in-order RV32I core; sits directly after the execute stage and before register writeback.
- Consumes execute's ALU result, destination register and load/store decode. Performs RV32I loads and stores over a simple request/ready/rvalid data bus.
- Forwards non-memory results to writeback. Stalls upstream while a bus transaction is outstanding.

Parameters:
- TIMEOUT, 255: max cycles a transaction may wait in REQ+WAIT_R before being aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_i  in  1  execute output valid this cycle
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- func3  in  3  RV32I width/sign field
- addr  in  32  effective address (execute result for load/store)
- alu_result  in  32  result for non-memory ops
- store_data  in  32  rs2 value for stores
- dest_i  in  5  destination register
- stall  out  1  high while not idle; upstream holds its outputs
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  bus accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- wb_valid  out  1  one-cycle writeback pulse
- wb_dest  out  5  writeback register (0 = no write)
- wb_data  out  32  writeback value
- fault  out  1  one-cycle fault pulse, coincident with wb_valid
- fault_cause  out  2  00 none, 01 misaligned, 10 illegal func3, 11 timeout

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops mem_req on the next edge and discards the access. No wb_valid is produced.
- FSM states: IDLE, REQ, WAIT_R. stall = (state != IDLE). Inputs are sampled only when valid_i && state==IDLE ("accept edge").
- Non-memory op (valid_i, !is_load, !is_store): after the accept edge, wb_valid=1, wb_dest=dest_i, wb_data=alu_result; stays in IDLE. Latency 1.
- Illegal func3 (loads: 011,110,111; stores: func3[2]=1 or 011): no bus access. After the accept edge, wb_valid=1, wb_dest=0, fault=1, cause=10.
- Store accept -> REQ with mem_req=1, mem_we=1, held stable until mem_ready is sampled high.
  - SB (000): wstrb = 0001<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH (001): wstrb = addr[1] ? 1100 : 0011, wdata = {2{store_data[15:0]}}.
  - SW (010): wstrb = 1111, wdata = store_data.
  - On the mem_ready edge: -> IDLE, mem_req=0, wb_valid=1, wb_dest=0.
- Load accept -> REQ with mem_req=1, mem_we=0, wstrb=0.
  - mem_ready without mem_rvalid -> WAIT_R, mem_req=0.
  - mem_ready with mem_rvalid in the same cycle skips WAIT_R.
  - In WAIT_R, mem_rvalid -> IDLE.
  - On completion: wb_valid=1, wb_dest=dest_i, wb_data = lane selected by addr[1:0]. LB/LH are sign-extended, LBU/LHU zero-extended, LW is the full word.
  - mem_rvalid is ignored outside REQ/WAIT_R.
- Minimum load/store latency: accept edge, then one REQ cycle, then wb_valid on the following cycle (2 edges).
- Timeout: the counter increments each cycle in REQ/WAIT_R and clears on IDLE. When it reaches TIMEOUT: -> IDLE, mem_req=0, wb_valid=1, wb_dest=0, fault=1, cause=11. Completion arriving on the same edge takes priority over timeout.
- wb_valid, fault and fault_cause are single-cycle pulses. wb_dest and wb_data hold until the next pulse.
- Non-memory ops arriving while stall=1 are held by upstream; none are dropped.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, are not issued to the bus. After the accept edge: wb_valid=1, wb_dest=0, fault=1, cause=01.
- Undefined: address bits below the access size are ignored (halfword uses addr[1] only, word uses neither). The access proceeds normally and cause 01 never occurs.

Test Plan:
- Non-memory op: alu_result=0x1234, dest_i=5 -> next cycle wb_valid=1, wb_dest=5, wb_data=0x1234, stall never high.
- SB with addr=0x103, store_data=0xAB -> mem_addr=0x100, mem_wstrb=1000, mem_wdata=0xABABABAB. Hold mem_ready=0 for 3 cycles: mem_req stays high and stall=1. After the ready edge: wb_valid=1, wb_dest=0.
- LB with addr=0x202, rdata=0x00800000, ready then rvalid 2 cycles later -> wb_data=0xFFFFFF80. Same access as LBU -> wb_data=0x00000080.
- LW with mem_ready=1 and mem_rvalid=1 in the same cycle, rdata=0xDEADBEEF -> WAIT_R skipped, wb_valid 2 edges after accept, wb_data=0xDEADBEEF.
- TIMEOUT=4 with mem_ready held 0 -> after 4 REQ cycles: mem_req=0, fault=1, cause=11, wb_dest=0. Separately, reset asserted in WAIT_R -> mem_req=0, no wb_valid.
- With MEM_ALIGN_CHECK_EN: LW at 0x102 -> no mem_req, fault=1, cause=01. Without it: mem_req issued with mem_addr=0x100.
